// File: rtl/usbhost_avs_bridge.sv
// Avalon-MM slave to single-outstanding strobe/ack bridge for the USB host core, with latched maskable IRQs.
// Optional macro USBHOST_BRIDGE_TIMEOUT_EN builds the core ack timeout counter and its sticky BRIDGE_STAT flag.
module usbhost_avs_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int IRQ_NUM        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  avs_s1_clk,
    input  logic                  avs_s1_reset_n,
    input  logic                  avs_s1_chipselect,
    input  logic [ADDR_WIDTH-1:0] avs_s1_address,
    input  logic                  avs_s1_read,
    input  logic                  avs_s1_write,
    input  logic [DATA_WIDTH-1:0] avs_s1_writedata,
    output logic [DATA_WIDTH-1:0] avs_s1_readdata,
    output logic                  avs_s1_waitrequest,
    output logic                  avs_s1_irq,
    output logic                  core_strobe_o,
    output logic                  core_we_o,
    output logic [ADDR_WIDTH-1:0] core_addr_o,
    output logic [DATA_WIDTH-1:0] core_data_o,
    input  logic [DATA_WIDTH-1:0] core_data_i,
    input  logic                  core_ack_i,
    input  logic [IRQ_NUM-1:0]    core_irq_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CORE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OFS_IRQ_STAT    = 2'd0;
    localparam logic [1:0] OFS_IRQ_MASK    = 2'd1;
    localparam logic [1:0] OFS_BRIDGE_STAT = 2'd2;

    logic [1:0]            state_reg, state_next;
    logic [DATA_WIDTH-1:0] readdata_reg, readdata_next;
    logic [ADDR_WIDTH-1:0] core_addr_reg, core_addr_next;
    logic [DATA_WIDTH-1:0] core_data_reg, core_data_next;
    logic                  core_we_reg, core_we_next;
    logic [IRQ_NUM-1:0]    irq_stat_reg, irq_stat_next;
    logic [IRQ_NUM-1:0]    irq_mask_reg, irq_mask_next;
    logic [IRQ_NUM-1:0]    irq_prev_reg;
    logic                  irq_out_reg;
    logic [IRQ_NUM-1:0]    irq_rise;
    logic [IRQ_NUM-1:0]    irq_clr;

    logic                  req;
    logic                  local_hit;
    logic [1:0]            local_ofs;
    logic                  local_acc;
    logic                  local_wr;
    logic                  stat_wr;
    logic                  mask_wr;
    logic [DATA_WIDTH-1:0] local_rdata;
    logic                  timeout_hit;
    logic                  timeout_flag;

    assign req       = avs_s1_chipselect & (avs_s1_read | avs_s1_write);
    // The top four addresses share all-ones upper bits; everything else belongs to the core.
    assign local_hit = &avs_s1_address[ADDR_WIDTH-1:2];
    assign local_ofs = avs_s1_address[1:0];
    assign local_acc = (state_reg == ST_IDLE) & req & local_hit;
    assign local_wr  = local_acc & ~avs_s1_read;
    assign stat_wr   = local_wr & (local_ofs == OFS_IRQ_STAT);
    assign mask_wr   = local_wr & (local_ofs == OFS_IRQ_MASK);

    assign avs_s1_waitrequest = req & (state_reg != ST_DONE);
    assign avs_s1_readdata    = readdata_reg;
    assign avs_s1_irq         = irq_out_reg;
    assign core_strobe_o      = (state_reg == ST_CORE);
    assign core_we_o          = core_we_reg;
    assign core_addr_o        = core_addr_reg;
    assign core_data_o        = core_data_reg;

    // A new rising edge beats a simultaneous write-1-to-clear so no event is lost.
    genvar gi;
    generate
        for (gi = 0; gi < IRQ_NUM; gi++) begin : g_irq
            assign irq_rise[gi]      = core_irq_i[gi] & ~irq_prev_reg[gi];
            assign irq_clr[gi]       = stat_wr & avs_s1_writedata[gi];
            assign irq_stat_next[gi] = irq_rise[gi] | (irq_stat_reg[gi] & ~irq_clr[gi]);
            assign irq_mask_next[gi] = mask_wr ? avs_s1_writedata[gi] : irq_mask_reg[gi];
        end
    endgenerate

`ifdef USBHOST_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_reg, tmo_cnt_next;
    logic        tmo_flag_reg, tmo_flag_next;
    logic        bstat_wr;

    assign bstat_wr     = local_wr & (local_ofs == OFS_BRIDGE_STAT);
    // Ack in the final allowed strobe cycle still counts as a normal completion.
    assign timeout_hit  = (state_reg == ST_CORE) & ~core_ack_i & (tmo_cnt_reg == TIMEOUT_LAST);
    assign tmo_cnt_next = ((state_reg == ST_CORE) & ~core_ack_i & ~timeout_hit) ?
                          tmo_cnt_reg + 16'd1 : 16'd0;
    assign tmo_flag_next = timeout_hit | (tmo_flag_reg & ~(bstat_wr & avs_s1_writedata[0]));
    assign timeout_flag  = tmo_flag_reg;

    always_ff @(posedge avs_s1_clk) begin
        if (!avs_s1_reset_n) begin
            tmo_cnt_reg  <= 16'd0;
            tmo_flag_reg <= 1'b0;
        end else begin
            tmo_cnt_reg  <= tmo_cnt_next;
            tmo_flag_reg <= tmo_flag_next;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        local_rdata = '0;
        case (local_ofs)
            OFS_IRQ_STAT:    local_rdata[IRQ_NUM-1:0] = irq_stat_reg;
            OFS_IRQ_MASK:    local_rdata[IRQ_NUM-1:0] = irq_mask_reg;
            OFS_BRIDGE_STAT: local_rdata[0]           = timeout_flag;
            default:         local_rdata              = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        readdata_next  = readdata_reg;
        core_addr_next = core_addr_reg;
        core_data_next = core_data_reg;
        core_we_next   = core_we_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (local_hit) begin
                        if (avs_s1_read) begin
                            readdata_next = local_rdata;
                        end
                        state_next = ST_DONE;
                    end else begin
                        core_addr_next = avs_s1_address;
                        core_data_next = avs_s1_writedata;
                        core_we_next   = ~avs_s1_read;
                        state_next     = ST_CORE;
                    end
                end
            end
            ST_CORE: begin
                if (core_ack_i) begin
                    if (!core_we_reg) begin
                        readdata_next = core_data_i;
                    end
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    if (!core_we_reg) begin
                        readdata_next = '1;
                    end
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge avs_s1_clk) begin
        if (!avs_s1_reset_n) begin
            state_reg     <= ST_IDLE;
            readdata_reg  <= '0;
            core_addr_reg <= '0;
            core_data_reg <= '0;
            core_we_reg   <= 1'b0;
            irq_stat_reg  <= '0;
            irq_mask_reg  <= '0;
            irq_prev_reg  <= '0;
            irq_out_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            readdata_reg  <= readdata_next;
            core_addr_reg <= core_addr_next;
            core_data_reg <= core_data_next;
            core_we_reg   <= core_we_next;
            irq_stat_reg  <= irq_stat_next;
            irq_mask_reg  <= irq_mask_next;
            irq_prev_reg  <= core_irq_i;
            irq_out_reg   <= |(irq_stat_reg & irq_mask_reg);
        end
    end

endmodule

// File: tb/tb_usbhost_avs_bridge.sv
// Directed self-checking bench for usbhost_avs_bridge; follows USBHOST_BRIDGE_TIMEOUT_EN when defined.
module tb_usbhost_avs_bridge;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       chipselect = 1'b0;
    logic [7:0] address = 8'h00;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       waitrequest;
    logic       irq;
    logic       core_strobe;
    logic       core_we;
    logic [7:0] core_addr;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata = 8'h00;
    logic       core_ack = 1'b0;
    logic [3:0] core_irq = 4'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    usbhost_avs_bridge #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .IRQ_NUM(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .avs_s1_clk(clk),
        .avs_s1_reset_n(reset_n),
        .avs_s1_chipselect(chipselect),
        .avs_s1_address(address),
        .avs_s1_read(rd),
        .avs_s1_write(wr),
        .avs_s1_writedata(writedata),
        .avs_s1_readdata(readdata),
        .avs_s1_waitrequest(waitrequest),
        .avs_s1_irq(irq),
        .core_strobe_o(core_strobe),
        .core_we_o(core_we),
        .core_addr_o(core_addr),
        .core_data_o(core_wdata),
        .core_data_i(core_rdata),
        .core_ack_i(core_ack),
        .core_irq_i(core_irq)
    );

    // One Avalon transfer starting at a cycle start; returns at the start of the cycle after DONE.
    // ack_after = k acks in the k-th strobe cycle (0 = never); on an expired limit the request stays up.
    task automatic xfer(input logic is_wr, input logic [7:0] a, input logic [7:0] wd,
                        input int ack_after, input int limit,
                        output logic [7:0] rdata, output int ncyc, output int nstb,
                        output logic hung, output logic stb_bad);
        logic done;
        done = 1'b0; ncyc = 0; nstb = 0; hung = 1'b0; stb_bad = 1'b0; rdata = 8'h00;
        chipselect = 1'b1; rd = ~is_wr; wr = is_wr; address = a; writedata = wd;
        for (int c = 0; c < limit; c++) begin
            if (core_strobe === 1'b1) begin
                nstb++;
                core_ack = (ack_after != 0) && (nstb == ack_after);
                if (core_addr !== a || core_we !== is_wr || (is_wr && core_wdata !== wd))
                    stb_bad = 1'b1;
            end else begin
                core_ack = 1'b0;
            end
            #3;
            ncyc++;
            if (waitrequest === 1'b0) begin
                rdata = readdata;
                if (core_strobe !== 1'b0) stb_bad = 1'b1;
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        core_ack = 1'b0;
        if (!done) begin
            hung = 1'b1;
            return;
        end
        chipselect = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] r; int n, s; logic h, sb;
        reset_n = 1'b0; chipselect = 1'b1; rd = 1'b1; address = 8'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3;
        total++; if (waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq got=%0b want=1", waitrequest); end
        total++; if (core_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%0b want=0", core_strobe); end
        total++; if (core_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", core_we); end
        total++; if (core_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", core_addr); end
        total++; if (core_wdata !== 8'h00) begin bad++; $display("FAIL reset_cdata got=%h want=00", core_wdata); end
        total++; if (readdata !== 8'h00) begin bad++; $display("FAIL reset_readdata got=%h want=00", readdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b want=0", irq); end
        chipselect = 1'b0; rd = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 8'hFC, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (h !== 1'b0 || r !== 8'h00) begin bad++; $display("FAIL reset_irqstat got=%h hung=%0b want=00", r, h); end
        $display("reset: irq_stat=%h", r);
    endtask

    task automatic test_core_read();
        logic [7:0] r; int n, s; logic h, sb;
        core_rdata = 8'hA5;
        xfer(1'b0, 8'h10, 8'h00, 3, 100, r, n, s, h, sb);
        total++; if (h !== 1'b0 || r !== 8'hA5) begin bad++; $display("FAIL core_read_data got=%h hung=%0b want=a5", r, h); end
        total++; if (n != 5) begin bad++; $display("FAIL core_read_cycles got=%0d want=5", n); end
        total++; if (s != 3) begin bad++; $display("FAIL core_read_strobes got=%0d want=3", s); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL core_read_bus got=%0b want=0", sb); end
        $display("core read 0x10: data=%h cycles=%0d strobes=%0d", r, n, s);
    endtask

    task automatic test_core_write();
        logic [7:0] r; int n, s; logic h, sb;
        core_rdata = 8'h00;
        xfer(1'b1, 8'h20, 8'h3C, 1, 100, r, n, s, h, sb);
        total++; if (h !== 1'b0 || n != 3) begin bad++; $display("FAIL core_write_cycles got=%0d hung=%0b want=3", n, h); end
        total++; if (s != 1) begin bad++; $display("FAIL core_write_strobes got=%0d want=1", s); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL core_write_bus got=%0b want=0", sb); end
        total++; if (r !== 8'hA5) begin bad++; $display("FAIL core_write_rdkeep got=%h want=a5", r); end
        $display("core write 0x20<=3c: cycles=%0d strobes=%0d readdata=%h", n, s, r);
    endtask

    task automatic test_back_to_back();
        logic [7:0] r; int n, s; logic h, sb;
        xfer(1'b1, 8'hFD, 8'h0F, 0, 20, r, n, s, h, sb);
        total++; if (h !== 1'b0 || n != 2 || s != 0) begin bad++; $display("FAIL b2b_wr got cyc=%0d stb=%0d want 2/0", n, s); end
        xfer(1'b0, 8'hFD, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (h !== 1'b0 || n != 2 || s != 0) begin bad++; $display("FAIL b2b_rd got cyc=%0d stb=%0d want 2/0", n, s); end
        total++; if (r !== 8'h0F) begin bad++; $display("FAIL b2b_mask got=%h want=0f", r); end
        $display("back-to-back mask: read=%h cycles=%0d", r, n);
        xfer(1'b1, 8'hFF, 8'hAA, 0, 20, r, n, s, h, sb);
        xfer(1'b0, 8'hFF, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (h !== 1'b0 || r !== 8'h00) begin bad++; $display("FAIL reserved_rd got=%h want=00", r); end
        $display("reserved 0xff: read=%h", r);
    endtask

    task automatic test_timeout();
        logic [7:0] r; int n, s; logic h, sb;
`ifdef USBHOST_BRIDGE_TIMEOUT_EN
        xfer(1'b0, 8'h40, 8'h00, 0, 50, r, n, s, h, sb);
        total++; if (h !== 1'b0 || r !== 8'hFF) begin bad++; $display("FAIL timeout_data got=%h hung=%0b want=ff", r, h); end
        total++; if (s != 8 || n != 10) begin bad++; $display("FAIL timeout_len got stb=%0d cyc=%0d want 8/10", s, n); end
        xfer(1'b0, 8'hFE, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (r !== 8'h01) begin bad++; $display("FAIL timeout_flag got=%h want=01", r); end
        xfer(1'b1, 8'hFE, 8'h01, 0, 20, r, n, s, h, sb);
        xfer(1'b0, 8'hFE, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (r !== 8'h00) begin bad++; $display("FAIL timeout_clr got=%h want=00", r); end
        $display("timeout: bridge_stat after w1c=%h", r);
`else
        xfer(1'b0, 8'h40, 8'h00, 0, 1000, r, n, s, h, sb);
        total++; if (h !== 1'b1 || core_strobe !== 1'b1) begin bad++; $display("FAIL no_timeout_stall got hung=%0b stb=%0b want 1/1", h, core_strobe); end
        $display("no timeout: hung=%0b strobes=%0d", h, s);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; chipselect = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        xfer(1'b1, 8'hFE, 8'h01, 0, 20, r, n, s, h, sb);
        xfer(1'b0, 8'hFE, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (h !== 1'b0 || r !== 8'h00) begin bad++; $display("FAIL no_timeout_bstat got=%h want=00", r); end
`endif
    endtask

    task automatic test_reset_mid_core();
        logic [7:0] r; int n, s; logic h, sb;
        xfer(1'b0, 8'h30, 8'h00, 0, 4, r, n, s, h, sb);
        total++; if (h !== 1'b1 || s != 3) begin bad++; $display("FAIL midrst_setup got hung=%0b stb=%0d want 1/3", h, s); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; chipselect = 1'b0; rd = 1'b0;
        #3;
        total++; if (core_strobe !== 1'b0) begin bad++; $display("FAIL midrst_strobe got=%0b want=0", core_strobe); end
        @(posedge clk); #1;
        xfer(1'b0, 8'hFE, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (h !== 1'b0 || r !== 8'h00) begin bad++; $display("FAIL midrst_flag got=%h want=00", r); end
        $display("reset mid-core: bridge_stat=%h", r);
    endtask

    task automatic test_irq();
        logic [7:0] r; int n, s; logic h, sb;
        xfer(1'b1, 8'hFD, 8'h05, 0, 20, r, n, s, h, sb);
        core_irq = 4'b0011;
        #3;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_c0 got=%0b want=0", irq); end
        @(posedge clk); #1;
        core_irq = 4'b0000;
        #3;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_c1 got=%0b want=0", irq); end
        @(posedge clk); #1;
        #3;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_c2 got=%0b want=1", irq); end
        @(posedge clk); #1;
        xfer(1'b0, 8'hFC, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (r !== 8'h03) begin bad++; $display("FAIL irq_stat got=%h want=03", r); end
        $display("irq: stat=%h irq=%0b", r, irq);
        xfer(1'b1, 8'hFC, 8'h01, 0, 20, r, n, s, h, sb);
        #3;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c_fall got=%0b want=0", irq); end
        @(posedge clk); #1;
        core_irq = 4'b0010;
        xfer(1'b1, 8'hFC, 8'h02, 0, 20, r, n, s, h, sb);
        xfer(1'b0, 8'hFC, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (r !== 8'h02) begin bad++; $display("FAIL irq_set_wins got=%h want=02", r); end
        $display("irq set-vs-clear: stat=%h", r);
        core_irq = 4'b0000;
        xfer(1'b1, 8'hFC, 8'h02, 0, 20, r, n, s, h, sb);
        xfer(1'b0, 8'hFC, 8'h00, 0, 20, r, n, s, h, sb);
        total++; if (r !== 8'h00) begin bad++; $display("FAIL irq_w1c_b1 got=%h want=00", r); end
        $display("irq clear bit1: stat=%h", r);
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_core_write();
        test_back_to_back();
        test_timeout();
        test_reset_mid_core();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
